// File: rtl/regfile_access_ctrl_pkg.sv
// Shared opcodes, controller states and default geometry for the
// register-file access controller and its bench.
package regfile_ctrl_pkg;

    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        OP_READ2   = 2'b00,
        OP_WRITE   = 2'b01,
        OP_RMW_ADD = 2'b10,
        OP_CLEAR   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        CLR,
        RESP
    } state_t;

endpackage

// File: rtl/regfile_access_ctrl_if.sv
// Command and response channels between an initiator (datapath control or
// debug loader) and the register-file access controller.
interface regfile_access_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_ra;
    logic [AW-1:0] cmd_rb;
    logic [AW-1:0] cmd_wn;
    logic [DW-1:0] cmd_wd;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_a;
    logic [DW-1:0] rsp_b;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_wn, cmd_wd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_a, rsp_b
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, cmd_wn, cmd_wd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_a, rsp_b
    );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Sequences the 32x32 register file through dual read, write, read-modify-write
// add and clear-all commands, returning results on a valid/ready response channel.
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  logic          clk,
    input  logic          reset,
    regfile_access_ctrl_if.slave bus,
    output logic [AW-1:0] rf_rna,
    output logic [AW-1:0] rf_rnb,
    input  logic [DW-1:0] rf_a,
    input  logic [DW-1:0] rf_b,
    output logic [AW-1:0] rf_wn,
    output logic [DW-1:0] rf_wd,
    output logic          rf_write
);

    state_t        state;
    op_t           op_q;
    logic [AW-1:0] ra_q;
    logic [AW-1:0] rb_q;
    logic [AW-1:0] wn_q;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] old_q;
    logic [AW-1:0] cnt;
    logic [DW-1:0] sum;

    // Carry out of the add is deliberately dropped: the sum wraps mod 2^DW.
    assign sum = old_q + wd_q;

    // Main sequencer: accepts one command in IDLE, walks the register file
    // through the required cycles, then holds the response until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= OP_READ2;
            ra_q          <= '0;
            rb_q          <= '0;
            wn_q          <= '0;
            wd_q          <= '0;
            old_q         <= '0;
            cnt           <= '0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_a     <= '0;
            bus.rsp_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q          <= op_t'(bus.cmd_op);
                        ra_q          <= bus.cmd_ra;
                        rb_q          <= bus.cmd_rb;
                        wn_q          <= bus.cmd_wn;
                        wd_q          <= bus.cmd_wd;
                        bus.cmd_ready <= 1'b0;
                        case (op_t'(bus.cmd_op))
                            OP_READ2, OP_RMW_ADD: state <= READ;
                            OP_WRITE:             state <= WRITE;
                            default: begin
                                cnt   <= AW'(1);
                                state <= CLR;
                            end
                        endcase
                    end
                end
                READ: begin
                    if (op_q == OP_RMW_ADD) begin
                        old_q <= rf_a;
                        state <= WRITE;
                    end else begin
                        bus.rsp_a     <= rf_a;
                        bus.rsp_b     <= rf_b;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                WRITE: begin
                    if (op_q == OP_RMW_ADD) begin
                        bus.rsp_a <= old_q;
                        bus.rsp_b <= sum;
                    end else begin
                        bus.rsp_a <= wd_q;
                        bus.rsp_b <= '0;
                    end
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                CLR: begin
                    cnt <= cnt + AW'(1);
                    if (cnt == AW'(NREG - 1)) begin
                        bus.rsp_a     <= DW'(NREG - 1);
                        bus.rsp_b     <= '0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Register-file port decode uses only registered state, so no command
    // input can ripple straight through to the register file.
    always_comb begin
        rf_rna   = '0;
        rf_rnb   = '0;
        rf_wn    = '0;
        rf_wd    = '0;
        rf_write = 1'b0;
        case (state)
            READ: begin
                rf_rna = ra_q;
                rf_rnb = rb_q;
            end
            WRITE: begin
                rf_wn    = wn_q;
                rf_wd    = (op_q == OP_RMW_ADD) ? sum : wd_q;
                rf_write = (wn_q != '0);
            end
            CLR: begin
                rf_wn    = cnt;
                rf_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
